// File: rtl/rom_addr_sequencer.sv
// ---------------------------------------------------------------------------
// rom_addr_sequencer : programmable up/down ROM address walker (once/loop)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rom_addr_sequencer #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic              dir,
  input  logic              loop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic              addr_valid,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  localparam logic [0:0]        S_IDLE = 1'b0;
  localparam logic [0:0]        S_RUN  = 1'b1;
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W-1:0] start_cfg_q, start_cfg_d;
  logic [ADDR_W-1:0] end_cfg_q, end_cfg_d;
  logic              dir_cfg_q, dir_cfg_d;
  logic              loop_cfg_q, loop_cfg_d;

  logic              at_end;
  logic              launch;

  assign at_end = (addr_q == end_cfg_q);
  assign launch = start && !stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      start_cfg_q <= '0;
      end_cfg_q   <= '0;
      dir_cfg_q   <= 1'b0;
      loop_cfg_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      start_cfg_q <= start_cfg_d;
      end_cfg_q   <= end_cfg_d;
      dir_cfg_q   <= dir_cfg_d;
      loop_cfg_q  <= loop_cfg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (launch) state_d = S_RUN;
      S_RUN: begin
        if (stop)                        state_d = S_IDLE;
        else if (!hold && at_end && !loop_cfg_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs: next values are computed here and land one cycle later.
  always_comb begin
    addr_d      = addr_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;
    start_cfg_d = start_cfg_q;
    end_cfg_d   = end_cfg_q;
    dir_cfg_d   = dir_cfg_q;
    loop_cfg_d  = loop_cfg_q;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (launch) begin
          start_cfg_d = start_addr;
          end_cfg_d   = end_addr;
          dir_cfg_d   = dir;
          loop_cfg_d  = loop;
          addr_d      = start_addr;
          valid_d     = 1'b1;
          busy_d      = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (!hold) begin
          if (!at_end) begin
            addr_d = dir_cfg_q ? (addr_q - ONE) : (addr_q + ONE);
          end else if (loop_cfg_q) begin
            addr_d = start_cfg_q;
            wrap_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign ADDRESS    = addr_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wrap       = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rom_addr_sequencer : directed + randomized bench against a queue model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rom_addr_sequencer;

  localparam int W = 5;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, stop = 1'b0, hold = 1'b0, dir = 1'b0, loop = 1'b0;
  logic [W-1:0] start_addr = '0, end_addr = '0;
  logic [W-1:0] ADDRESS;
  logic         addr_valid, busy, done, wrap;

  rom_addr_sequencer #(.ADDR_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold), .dir(dir),
    .loop(loop), .start_addr(start_addr), .end_addr(end_addr),
    .ADDRESS(ADDRESS), .addr_valid(addr_valid), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  logic [W+3:0] dut_v;
  assign dut_v = {ADDRESS, addr_valid, busy, done, wrap};

  int errors = 0;
  int checks = 0;

  // Reference model: a run is the list of addresses it must visit.
  int           seq_q[$];
  bit           m_run;
  logic [W-1:0] m_addr;
  bit           m_valid, m_busy, m_done, m_wrap;
  logic [W-1:0] c_start, c_end;
  bit           c_dir, c_loop;

  function automatic void build_seq();
    int len, a;
    seq_q.delete();
    if (c_dir) len = ((int'(c_start) - int'(c_end)) % M + M) % M + 1;
    else       len = ((int'(c_end) - int'(c_start)) % M + M) % M + 1;
    for (int i = 0; i < len; i++) begin
      a = c_dir ? int'(c_start) - i : int'(c_start) + i;
      seq_q.push_back(((a % M) + M) % M);
    end
  endfunction

  function automatic void model_reset();
    seq_q.delete();
    m_run = 0; m_addr = '0; m_valid = 0; m_busy = 0; m_done = 0; m_wrap = 0;
  endfunction

  function automatic void model_step();
    m_done = 0;
    m_wrap = 0;
    if (rst) begin
      model_reset();
    end else if (!m_run) begin
      m_valid = 0;
      m_busy  = 0;
      if (start && !stop) begin
        c_start = start_addr; c_end = end_addr; c_dir = dir; c_loop = loop;
        build_seq();
        m_addr  = W'(seq_q.pop_front());
        m_valid = 1; m_busy = 1; m_run = 1;
      end
    end else if (stop) begin
      m_run = 0; m_valid = 0; m_busy = 0;
    end else if (!hold) begin
      if (seq_q.size() > 0) begin
        m_addr = W'(seq_q.pop_front());
      end else if (c_loop) begin
        build_seq();
        m_addr = W'(seq_q.pop_front());
        m_wrap = 1;
      end else begin
        m_run = 0; m_valid = 0; m_busy = 0; m_done = 1;
      end
    end
  endfunction

  function automatic logic [W+3:0] model_vec();
    return {m_addr, m_valid, m_busy, m_done, m_wrap};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic launch(input logic [W-1:0] sa, input logic [W-1:0] ea,
                        input logic d, input logic l);
    start_addr = sa; end_addr = ea; dir = d; loop = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if (dut_v !== '0) begin
      errors++; $display("FAIL reset_async: got %h expected 0", dut_v);
    end
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (dut_v !== model_vec()) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_v, model_vec());
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_a;
    launch(5'd3, 5'd7, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      exp_a = W'(3 + i);
      checks++;
      if (dut_v !== model_vec()) begin
        errors++; $display("FAIL basic_model c%0d: got %h expected %h", i, dut_v, model_vec());
      end
      checks++;
      if (i < 5 && !(ADDRESS === exp_a && addr_valid === 1'b1 && done === 1'b0)) begin
        errors++; $display("FAIL basic_addr c%0d: got a=%0d v=%b expected a=%0d v=1", i, ADDRESS, addr_valid, exp_a);
      end else if (i == 5 && !(done === 1'b1 && busy === 1'b0 && addr_valid === 1'b0 && ADDRESS === 5'd7)) begin
        errors++; $display("FAIL basic_done: got d=%b b=%b v=%b a=%0d expected d=1 b=0 v=0 a=7", done, busy, addr_valid, ADDRESS);
      end
      tick();
    end
  endtask

  task automatic test_down_wrap();
    logic [W-1:0] exp_seq [4];
    exp_seq[0] = 5'd1; exp_seq[1] = 5'd0; exp_seq[2] = 5'd31; exp_seq[3] = 5'd30;
    launch(5'd1, 5'd30, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_v !== model_vec()) begin
        errors++; $display("FAIL down_model c%0d: got %h expected %h", i, dut_v, model_vec());
      end
      checks++;
      if (i < 4 && (ADDRESS !== exp_seq[i] || addr_valid !== 1'b1)) begin
        errors++; $display("FAIL down_addr c%0d: got %0d/%b expected %0d/1", i, ADDRESS, addr_valid, exp_seq[i]);
      end else if (i == 4 && done !== 1'b1) begin
        errors++; $display("FAIL down_done: got %b expected 1", done);
      end
      tick();
    end
  endtask

  task automatic test_full_range();
    int  cnt  = 0;
    bit  seen = 0;
    launch(5'd0, 5'd31, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (dut_v !== model_vec()) begin
        errors++; $display("FAIL full_model c%0d: got %h expected %h", i, dut_v, model_vec());
      end
      if (addr_valid) cnt++;
      if (done) begin seen = 1; break; end
      tick();
    end
    checks++;
    if (!seen || cnt != 32) begin
      errors++; $display("FAIL full_len: got valid=%0d done=%b expected valid=32 done=1", cnt, seen);
    end
    tick();
  endtask

  task automatic test_loop();
    logic [W-1:0] exp_a;
    launch(5'd0, 5'd2, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      exp_a = W'(i % 3);
      checks++;
      if (dut_v !== model_vec()) begin
        errors++; $display("FAIL loop_model c%0d: got %h expected %h", i, dut_v, model_vec());
      end
      checks++;
      if (ADDRESS !== exp_a || wrap !== (i == 3 || i == 6) || done !== 1'b0) begin
        errors++; $display("FAIL loop_seq c%0d: got a=%0d w=%b d=%b expected a=%0d w=%b d=0", i, ADDRESS, wrap, done, exp_a, (i == 3 || i == 6));
      end
      if (i < 6) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || addr_valid !== 1'b0 || done !== 1'b0 || dut_v !== model_vec()) begin
      errors++; $display("FAIL loop_stop: got %h expected %h", dut_v, model_vec());
    end
    tick();
  endtask

  task automatic test_hold();
    int n5 = 0;
    launch(5'd3, 5'd10, 1'b0, 1'b0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_v !== model_vec()) begin
        errors++; $display("FAIL hold_model c%0d: got %h expected %h", i, dut_v, model_vec());
      end
      if (ADDRESS == 5'd5 && addr_valid) n5++;
      hold = (i < 3);
      if (i < 4) tick();
    end
    checks++;
    if (n5 != 4 || ADDRESS !== 5'd6) begin
      errors++; $display("FAIL hold_len: got n5=%0d a=%0d expected n5=4 a=6", n5, ADDRESS);
    end
    hold = 1'b1; stop = 1'b1;
    tick();
    hold = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || addr_valid !== 1'b0 || done !== 1'b0 || ADDRESS !== 5'd6) begin
      errors++; $display("FAIL hold_stop: got %h expected b=0 v=0 d=0 a=6", dut_v);
    end
    tick();
  endtask

  task automatic test_corner();
    launch(5'd9, 5'd9, 1'b0, 1'b0);
    checks++;
    if (ADDRESS !== 5'd9 || addr_valid !== 1'b1 || dut_v !== model_vec()) begin
      errors++; $display("FAIL single_addr: got %h expected %h", dut_v, model_vec());
    end
    tick();
    checks++;
    if (done !== 1'b1 || addr_valid !== 1'b0 || dut_v !== model_vec()) begin
      errors++; $display("FAIL single_done: got %h expected %h", dut_v, model_vec());
    end
    start_addr = 5'd17; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || addr_valid !== 1'b0 || ADDRESS !== 5'd9) begin
      errors++; $display("FAIL start_stop_idle: got %h expected b=0 v=0 a=9", dut_v);
    end
  endtask

  task automatic test_back_to_back();
    launch(5'd5, 5'd6, 1'b0, 1'b0);
    tick();
    start_addr = 5'd20; end_addr = 5'd21; start = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1 || dut_v !== model_vec()) begin
      errors++; $display("FAIL b2b_done: got %h expected %h", dut_v, model_vec());
    end
    tick();
    start = 1'b0;
    checks++;
    if (ADDRESS !== 5'd20 || addr_valid !== 1'b1 || busy !== 1'b1 || dut_v !== model_vec()) begin
      errors++; $display("FAIL b2b_restart: got %h expected %h", dut_v, model_vec());
    end
    tick(); tick();
  endtask

  task automatic test_async_reset();
    launch(5'd10, 5'd20, 1'b0, 1'b0);
    tick(); tick();
    checks++;
    if (ADDRESS !== 5'd12) begin
      errors++; $display("FAIL areset_pre: got %0d expected 12", ADDRESS);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_v !== '0) begin
      errors++; $display("FAIL areset_now: got %h expected 0", dut_v);
    end
    tick();
    rst = 1'b0;
    launch(5'd4, 5'd6, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_v !== model_vec()) begin
        errors++; $display("FAIL areset_after c%0d: got %h expected %h", i, dut_v, model_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      start      = ($urandom_range(0, 9) < 3);
      stop       = ($urandom_range(0, 24) == 0);
      hold       = ($urandom_range(0, 4) == 0);
      dir        = $urandom_range(0, 1) == 1;
      loop       = $urandom_range(0, 3) == 0;
      start_addr = W'($urandom);
      end_addr   = ($urandom_range(0, 3) == 0) ? W'($urandom)
                                               : W'(start_addr + (dir ? -$urandom_range(0, 4) : $urandom_range(0, 4)));
      tick();
      checks++;
      if (dut_v !== model_vec() || (done && wrap)) begin
        errors++; $display("FAIL random c%0d: got %h expected %h", i, dut_v, model_vec());
      end
    end
    start = 1'b0; stop = 1'b0; hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_down_wrap();
    test_full_range();
    test_loop();
    test_hold();
    test_corner();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rom_addr_sequencer.md
Name: rom_addr_sequencer

Overview:
Parametrised synchronous ROM address generator; successor to the fixed 5-bit ripple up-counter.
- Walks ADDRESS from a programmable start address to a programmable end address, counting up or down.
- Runs once or loops continuously, supports pause (hold) and abort (stop).
- Sits between the control FSM and the ROM address input; flags each valid address with addr_valid.

Parameters:
ADDR_W, 5, address width in bits; legal range 1..16.

Ports:
clk  in  1  single system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin a sequence; sampled only in IDLE.
stop  in  1  abort the running sequence.
hold  in  1  pause advancing while high.
dir  in  1  0 = count up, 1 = count down; captured at start.
loop  in  1  1 = wrap to start_addr after end_addr; captured at start.
start_addr  in  ADDR_W  first address; captured at start.
end_addr  in  ADDR_W  last address; captured at start.
ADDRESS  out  ADDR_W  current ROM address, registered.
addr_valid  out  1  ADDRESS is a live sequence member this cycle.
busy  out  1  sequencer in RUN.
done  out  1  one-cycle pulse after the last address of a non-loop run.
wrap  out  1  one-cycle pulse when a loop run reloads start_addr.

Behaviour:
- Reset (async, any time, including mid-run):
  - Outputs: ADDRESS=0, addr_valid=0, busy=0, done=0, wrap=0.
  - Internal: state=IDLE; captured config cleared to 0.
- States: IDLE, RUN. All outputs are registered; no combinational input-to-output paths.
- IDLE:
  - start=1 and stop=0: capture start_addr, end_addr, dir and loop into config registers. Next cycle: ADDRESS=start_addr, addr_valid=1, busy=1, state=RUN.
  - stop=1 in IDLE, including together with start: remain in IDLE.
  - ADDRESS holds its last value in IDLE.
- RUN, priority order stop > hold > advance:
  - stop=1: next cycle state=IDLE, busy=0, addr_valid=0, done=0, ADDRESS unchanged.
  - hold=1: ADDRESS, addr_valid and busy unchanged; no pulses.
  - ADDRESS != end_cfg: ADDRESS <= ADDRESS+1 (up) or ADDRESS-1 (down), modulo 2^ADDR_W. Wrap through 0 / all-ones is legal and not flagged.
  - ADDRESS == end_cfg and loop_cfg=1: ADDRESS <= start_cfg, wrap=1 in that same next cycle.
  - ADDRESS == end_cfg and loop_cfg=0: next cycle state=IDLE, done=1 for one cycle, busy=0, addr_valid=0, ADDRESS holds end_cfg.
  - start while in RUN: ignored.
  - Config inputs changing during RUN: no effect.
- Sequence length (non-loop, no hold), with each address valid exactly one cycle:
  - up: ((end-start) mod 2^ADDR_W)+1
  - down: ((start-end) mod 2^ADDR_W)+1
- start_addr == end_addr: one address valid for one cycle, then done (or wrap each cycle if loop=1).
- done and wrap are never asserted simultaneously. done is never asserted on a stop abort.
- Back-to-back runs: start accepted in the cycle done=1, since state is already IDLE.

Test Plan:
1. ADDR_W=5, up, start_addr=3, end_addr=7, loop=0 -> ADDRESS 3,4,5,6,7 with addr_valid=1 for 5 cycles; next cycle done=1, busy=0, ADDRESS=7.
2. Down through zero: dir=1, start_addr=1, end_addr=30 -> ADDRESS 1,0,31,30; then done pulse. Full range up 0->31 yields 32 valid cycles.
3. Loop: start_addr=0, end_addr=2, loop=1 -> ADDRESS 0,1,2,0,1,2, with wrap=1 on each return to 0; stop -> next cycle busy=0, addr_valid=0, done=0.
4. Hold: up run reaches 5, hold=1 for 3 cycles -> ADDRESS=5 for 4 consecutive cycles, then 6; stop asserted together with hold -> abort wins.
5. Corner inputs: start_addr=end_addr=9 -> single valid cycle, then done. start and stop high in the same IDLE cycle -> stays IDLE, busy=0.
6. Reset: assert rst asynchronously mid-RUN at ADDRESS=12 -> all outputs 0 without waiting for a clock edge; after release, start begins a fresh run normally.
